// File: rtl/core_mem_ctrl.sv
// core_mem_ctrl: MEM-stage data-cache controller.
// Runs one cache access per op through a three-state FSM, stalls the
// pipeline while that access is outstanding, and keeps the load-linked
// reservation. The reservation is cleared by matching stores, by a
// committed SC, or by a ring snoop.
module core_mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic        mem_ll_mem,
   input  logic        mem_sc_mem,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_reg_read2,
   input  logic        dc_ack,
   input  logic [31:0] dc_rdata,
   input  logic        snoop_inv,
   input  logic [31:0] snoop_addr,
   output logic        dc_req,
   output logic        dc_we,
   output logic [31:0] dc_addr,
   output logic [31:0] dc_wdata,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        sc_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   state_t      w_state_eff;

   // Op decode. A read request overrides any write request.
   logic        w_rd;
   logic        w_wr;
   logic        w_op;
   logic        w_sc;
   logic        w_sc_fail;

   // One-cycle events produced by the next-state logic
   logic        w_start;      // IDLE -> WAIT
   logic        w_finish;     // WAIT -> DONE
   logic        w_fail_now;   // IDLE -> DONE, failed SC

   // Op kind held for the access in flight
   logic        r_op_rd;
   logic        r_op_ll;
   logic        r_op_sc;

   // Cache request registers
   logic        r_dc_we;
   logic [31:0] r_dc_addr;
   logic [31:0] r_dc_wdata;

   // Results
   logic [31:0] r_mem_rdata;
   logic        r_sc_result;

   // Reservation
   logic        r_link_valid;
   logic [29:0] r_link_addr;
   logic        w_snoop_hit;
   logic        w_snoop_ll_hit;
   logic        w_store_hit;

   // Only whole-word addresses matter, so the byte offsets are dropped.
   logic        w_unused;
   assign w_unused = ^{mem_alu_result[1:0], snoop_addr[1:0]};

   assign w_rd      = mem_mem_read | mem_ll_mem;
   assign w_wr      = (mem_mem_write | mem_sc_mem) & ~w_rd;
   assign w_op      = mem_mem_read | mem_mem_write | mem_ll_mem | mem_sc_mem;
   assign w_sc      = mem_sc_mem & ~w_rd;
   assign w_sc_fail = w_sc & (~r_link_valid | (r_link_addr != mem_alu_result[31:2]));

   // While reset is held, the stall must behave as if the FSM were already idle.
   assign w_state_eff = rst ? S_IDLE : r_state;
   assign mem_stall   = ((w_state_eff == S_IDLE) & w_op) | (w_state_eff == S_WAIT);

   assign dc_req    = (r_state == S_WAIT);
   assign dc_we     = r_dc_we;
   assign dc_addr   = r_dc_addr;
   assign dc_wdata  = r_dc_wdata;
   assign mem_rdata = r_mem_rdata;
   assign sc_result = r_sc_result;

   // Snoop hits are checked against the held reservation and against the
   // word that a completing LL is about to reserve.
   assign w_snoop_hit    = snoop_inv & (snoop_addr[31:2] == r_link_addr);
   assign w_snoop_ll_hit = snoop_inv & (snoop_addr[31:2] == r_dc_addr[31:2]);
   assign w_store_hit    = r_dc_we & ~r_op_sc & (r_dc_addr[31:2] == r_link_addr);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic and transition strobes
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_finish    = 1'b0;
      w_fail_now  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_op) begin
               if (w_sc_fail) begin
                  w_state_nxt = S_DONE;
                  w_fail_now  = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_start     = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (dc_ack) begin
               w_state_nxt = S_DONE;
               w_finish    = 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture the request and op kind when the access is launched
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dc_we    <= 1'b0;
         r_dc_addr  <= 32'd0;
         r_dc_wdata <= 32'd0;
         r_op_rd    <= 1'b0;
         r_op_ll    <= 1'b0;
         r_op_sc    <= 1'b0;
      end else if (w_start) begin
         r_dc_we    <= w_wr;
         r_dc_addr  <= {mem_alu_result[31:2], 2'b00};
         r_dc_wdata <= mem_reg_read2;
         r_op_rd    <= w_rd;
         r_op_ll    <= mem_ll_mem;
         r_op_sc    <= w_sc;
      end
   end

   // Load data and SC status, each held until the next op of its kind
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_rdata <= 32'd0;
         r_sc_result <= 1'b0;
      end else begin
         if (w_finish & r_op_rd) r_mem_rdata <= dc_rdata;
         if (w_fail_now)              r_sc_result <= 1'b0;
         else if (w_finish & r_op_sc) r_sc_result <= 1'b1;
      end
   end

   // Reservation. When a snoop and a completing LL hit the same word, the
   // snoop wins. A committing SC is never aborted, since it already passed
   // its link check in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_link_valid <= 1'b0;
         r_link_addr  <= 30'd0;
      end else if (w_finish & r_op_ll) begin
         r_link_addr  <= r_dc_addr[31:2];
         r_link_valid <= ~w_snoop_ll_hit;
      end else if (w_snoop_hit | (w_finish & r_op_sc) | (w_finish & w_store_hit)) begin
         r_link_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_core_mem_ctrl.sv
// Testbench for core_mem_ctrl. It plays the role of both the pipeline and the
// data cache. A transaction-level model predicts the outputs for every cycle,
// and one negedge process compares the DUT against those predictions.
module tb_core_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_mem_read, mem_mem_write, mem_ll_mem, mem_sc_mem;
   logic [31:0] mem_alu_result, mem_reg_read2;
   logic        dc_ack;
   logic [31:0] dc_rdata;
   logic        snoop_inv;
   logic [31:0] snoop_addr;
   logic        dc_req, dc_we, mem_stall, sc_result;
   logic [31:0] dc_addr, dc_wdata, mem_rdata;

   core_mem_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_ll_mem(mem_ll_mem), .mem_sc_mem(mem_sc_mem),
      .mem_alu_result(mem_alu_result), .mem_reg_read2(mem_reg_read2),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata),
      .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .mem_stall(mem_stall), .mem_rdata(mem_rdata), .sc_result(sc_result)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          stall_cnt = 0;
   logic        chk_en = 1'b0;
   logic        noise = 1'b0;

   // Expected outputs for the current cycle
   logic        e_req, e_we, e_stall, e_sc;
   logic [31:0] e_addr, e_wdata, e_rdata;

   // Model of the reservation
   logic        m_lv;
   logic [29:0] m_la;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("dc_req",    32'(dc_req),    32'(e_req));
         cmp("dc_we",     32'(dc_we),     32'(e_we));
         cmp("dc_addr",   dc_addr,        e_addr);
         cmp("dc_wdata",  dc_wdata,       e_wdata);
         cmp("mem_stall", 32'(mem_stall), 32'(e_stall));
         cmp("mem_rdata", mem_rdata,      e_rdata);
         cmp("sc_result", 32'(sc_result), 32'(e_sc));
         if (mem_stall) stall_cnt++;
      end
   end

   function automatic logic [31:0] pick_addr();
      logic [31:0] b;
      case ($urandom_range(0, 3))
         0:       b = 32'h200;
         1:       b = 32'h204;
         2:       b = 32'h300;
         default: b = 32'h1000;
      endcase
      return b | 32'($urandom_range(0, 3));
   endfunction

   task automatic set_ops(input logic rd, input logic wr, input logic ll, input logic sc);
      mem_mem_read = rd; mem_mem_write = wr; mem_ll_mem = ll; mem_sc_mem = sc;
   endtask

   // Drives random ack and snoop traffic when noise is enabled.
   // An ack outside WAIT must have no effect.
   task automatic noise_in();
      dc_ack     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      dc_rdata   = $urandom;
      snoop_inv  = noise && ($urandom_range(0, 5) == 0);
      snoop_addr = pick_addr();
   endtask

   task automatic snoop_upd();
      if (snoop_inv && snoop_addr[31:2] == m_la) m_lv = 1'b0;
   endtask

   task automatic idle(input int n, input logic snp, input logic [31:0] sa);
      repeat (n) begin
         @(posedge clk); #1;
         set_ops(0, 0, 0, 0);
         noise_in();
         if (snp) begin snoop_inv = 1'b1; snoop_addr = sa; end
         e_stall = 1'b0; e_req = 1'b0;
         snoop_upd();
      end
   endtask

   // Runs one op as the pipeline would. The cache acks after lat cycles.
   // If snp_last is set, a snoop to the same address lands on the ack cycle.
   task automatic do_op(input logic rd, input logic wr, input logic ll, input logic sc,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdv, input int lat, input logic snp_last);
      logic r, w, isc, fsc;
      logic [29:0] wa;
      r   = rd | ll;
      w   = (wr | sc) & ~r;
      isc = sc & ~r;
      wa  = addr[31:2];
      fsc = isc && !(m_lv && m_la == wa);
      @(posedge clk); #1;
      set_ops(rd, wr, ll, sc);
      mem_alu_result = addr; mem_reg_read2 = data;
      noise_in();
      stall_cnt = 0;
      e_stall = 1'b1; e_req = 1'b0;
      snoop_upd();
      if (fsc) begin
         @(posedge clk); #1;
         noise_in();
         e_stall = 1'b0; e_sc = 1'b0;
         snoop_upd();
      end else begin
         for (int k = 0; k < lat; k++) begin
            @(posedge clk); #1;
            noise_in();
            dc_ack = (k == lat - 1);
            if (k == lat - 1) dc_rdata = rdv;
            if (snp_last && k == lat - 1) begin snoop_inv = 1'b1; snoop_addr = addr; end
            e_stall = 1'b1; e_req = 1'b1;
            e_addr = {wa, 2'b00}; e_we = w; e_wdata = data;
            if (k < lat - 1) snoop_upd();
            else if (ll) begin
               m_la = wa;
               m_lv = !(snoop_inv && snoop_addr[31:2] == wa);
            end else begin
               snoop_upd();
               if (isc) m_lv = 1'b0;
               else if (w && wa == m_la) m_lv = 1'b0;
            end
         end
         @(posedge clk); #1;
         noise_in();
         e_stall = 1'b0; e_req = 1'b0;
         if (r) e_rdata = rdv;
         if (isc) e_sc = 1'b1;
         snoop_upd();
      end
   endtask

   initial begin
      rst = 1'b1;
      set_ops(0, 0, 0, 0);
      mem_alu_result = 0; mem_reg_read2 = 0;
      dc_ack = 0; dc_rdata = 0; snoop_inv = 0; snoop_addr = 0;
      e_req = 0; e_we = 0; e_stall = 0; e_sc = 0;
      e_addr = 0; e_wdata = 0; e_rdata = 0;
      m_lv = 0; m_la = 0;
      chk_en = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      cmp("reset_rdata", mem_rdata, 32'h0);
      cmp("reset_addr", dc_addr, 32'h0);
      rst = 1'b0;
      idle(1, 0, 0);

      // Load with a 3-cycle cache latency
      do_op(1, 0, 0, 0, 32'h0000_1007, 32'h0, 32'hDEAD_BEEF, 3, 0);
      cmp("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
      cmp("ld_addr", dc_addr, 32'h0000_1004);
      cmp("ld_we", 32'(dc_we), 32'h0);
      cmp("ld_stall_cycles", 32'(stall_cnt), 32'd4);
      idle(1, 0, 0);

      // LL followed by a passing SC; a second SC then fails
      do_op(0, 0, 1, 0, 32'h200, 32'h0, 32'h1111_2222, 1, 0);
      idle(1, 0, 0);
      do_op(0, 0, 0, 1, 32'h200, 32'h55, 32'h0, 1, 0);
      cmp("sc_pass_result", 32'(sc_result), 32'h1);
      cmp("sc_pass_we", 32'(dc_we), 32'h1);
      cmp("sc_pass_wdata", dc_wdata, 32'h55);
      cmp("sc_pass_stall_cycles", 32'(stall_cnt), 32'd2);
      idle(1, 0, 0);
      do_op(0, 0, 0, 1, 32'h200, 32'h66, 32'h0, 1, 0);
      cmp("sc_again_result", 32'(sc_result), 32'h0);
      cmp("sc_again_stall_cycles", 32'(stall_cnt), 32'd1);
      idle(1, 0, 0);

      // SC that fails because a snoop hit the reserved word
      do_op(0, 0, 1, 0, 32'h200, 32'h0, 32'h3333_4444, 2, 0);
      idle(1, 1, 32'h203);
      do_op(0, 0, 0, 1, 32'h200, 32'h77, 32'h0, 1, 0);
      cmp("sc_snoop_result", 32'(sc_result), 32'h0);
      cmp("sc_snoop_stall_cycles", 32'(stall_cnt), 32'd1);
      idle(1, 0, 0);

      // Snoop on the same edge as LL completion: the snoop wins
      do_op(0, 0, 1, 0, 32'h200, 32'h0, 32'h5555_6666, 2, 1);
      idle(1, 0, 0);
      do_op(0, 0, 0, 1, 32'h200, 32'h88, 32'h0, 1, 0);
      cmp("ll_snoop_sc_result", 32'(sc_result), 32'h0);
      cmp("ll_snoop_stall_cycles", 32'(stall_cnt), 32'd1);
      idle(1, 0, 0);

      // Snoop while a passing SC is in WAIT: the SC still commits
      do_op(0, 0, 1, 0, 32'h200, 32'h0, 32'h7777_8888, 1, 0);
      idle(1, 0, 0);
      do_op(0, 0, 0, 1, 32'h200, 32'h99, 32'h0, 3, 1);
      cmp("sc_wait_snoop_result", 32'(sc_result), 32'h1);
      idle(1, 0, 0);

      // Reset pulsed while a store is in WAIT; a late ack must be ignored
      do_op(0, 0, 1, 0, 32'h300, 32'h0, 32'h0BAD_F00D, 1, 0);
      idle(1, 0, 0);
      @(posedge clk); #1;
      set_ops(0, 1, 0, 0); mem_alu_result = 32'h300; mem_reg_read2 = 32'hA5A5;
      dc_ack = 0; e_stall = 1; e_req = 0;
      @(posedge clk); #1;
      e_stall = 1; e_req = 1; e_addr = 32'h300; e_we = 1; e_wdata = 32'hA5A5;
      @(posedge clk); #1;
      rst = 1'b1; set_ops(0, 0, 0, 0);
      e_stall = 0; e_req = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      e_req = 0; e_addr = 0; e_we = 0; e_wdata = 0; e_rdata = 0; e_sc = 0;
      m_lv = 0; m_la = 0;
      @(posedge clk); #1;
      dc_ack = 1'b1;
      @(posedge clk); #1;
      dc_ack = 1'b0;
      cmp("rst_req", 32'(dc_req), 32'h0);
      cmp("rst_sc", 32'(sc_result), 32'h0);
      cmp("rst_rdata", mem_rdata, 32'h0);
      cmp("rst_addr", dc_addr, 32'h0);
      cmp("rst_wdata", dc_wdata, 32'h0);
      do_op(0, 0, 0, 1, 32'h300, 32'h1, 32'h0, 1, 0);
      cmp("rst_link_sc_stall_cycles", 32'(stall_cnt), 32'd1);
      idle(1, 0, 0);

      // Read and write together: the access completes as a load
      do_op(1, 1, 0, 0, 32'h1000, 32'h77, 32'h1234_5678, 2, 0);
      cmp("rw_we", 32'(dc_we), 32'h0);
      cmp("rw_rdata", mem_rdata, 32'h1234_5678);
      idle(1, 0, 0);

      // Randomized op mix with background ack and snoop noise
      noise = 1'b1;
      repeat (300) begin
         int kind;
         kind = $urandom_range(0, 5);
         case (kind)
            0:       do_op(1, 0, 0, 0, pick_addr(), $urandom, $urandom, $urandom_range(1, 4), 0);
            1:       do_op(0, 1, 0, 0, pick_addr(), $urandom, $urandom, $urandom_range(1, 4), 0);
            2:       do_op(0, 0, 1, 0, pick_addr(), $urandom, $urandom, $urandom_range(1, 4), 0);
            3, 4:    do_op(0, 0, 0, 1, pick_addr(), $urandom, $urandom, $urandom_range(1, 4), 0);
            default: do_op(1, 1, 0, 0, pick_addr(), $urandom, $urandom, $urandom_range(1, 4), 0);
         endcase
         idle($urandom_range(0, 2), 0, 0);
      end
      noise = 1'b0;
      idle(2, 0, 0);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/core_mem_ctrl.md
CORE_MEM_CTRL -- requirements
Module: core_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, both sampled on the rising edge of clk.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mem_mem_read  in  1  load in the MEM stage.
- mem_mem_write  in  1  store in the MEM stage.
- mem_ll_mem  in  1  load-linked in the MEM stage.
- mem_sc_mem  in  1  store-conditional in the MEM stage.
- mem_alu_result  in  32  effective address.
- mem_reg_read2  in  32  store data.
- dc_ack  in  1  data-cache access complete.
- dc_rdata  in  32  cache read data, valid with dc_ack.
- snoop_inv  in  1  remote-write invalidate strobe from the ring.
- snoop_addr  in  32  address of the remote write.
- dc_req  out  1  cache request, held until dc_ack.
- dc_we  out  1  write enable, qualifies dc_req.
- dc_addr  out  32  word address; bits [1:0] are always 0.
- dc_wdata  out  32  write data.
- mem_stall  out  1  freezes the EX/MEM register and upstream stages.
- mem_rdata  out  32  load / load-linked result.
- sc_result  out  1  store-conditional success (1) or failure (0).

Function
REQ-003 An op SHALL be present when any of mem_mem_read, mem_mem_write, mem_ll_mem or mem_sc_mem is 1.
REQ-004 Op class SHALL be decoded as follows:
- read = mem_mem_read or mem_ll_mem.
- write = mem_mem_write or mem_sc_mem.
- if both read and write are set, read SHALL win and no write is issued.
REQ-005 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-006 In IDLE with an op present, the FSM SHALL go to WAIT, except for an SC with a failed link (REQ-012).
REQ-007 On the IDLE->WAIT transition, the block SHALL register dc_addr = {mem_alu_result[31:2],2'b00}, dc_wdata = mem_reg_read2 and dc_we = write.
REQ-008 In WAIT, dc_req SHALL be 1, and dc_addr, dc_wdata and dc_we SHALL be held stable.
REQ-009 In WAIT with dc_ack = 1, the FSM SHALL go to DONE; for a read it SHALL capture dc_rdata into mem_rdata on that edge.
REQ-010 DONE SHALL last exactly one cycle and then return to IDLE; dc_req SHALL be 0 in IDLE and DONE.
REQ-011 Stall and latency rules:
- mem_stall SHALL be combinational: (IDLE and op present) or WAIT; it SHALL be 0 in DONE.
- The pipeline therefore advances on the DONE edge, and each access takes exactly one IDLE cycle, N WAIT cycles and one DONE cycle.
- A 1-cycle-ack access therefore stalls the pipeline for 2 cycles.
REQ-012 Link state SHALL be a link_valid bit and a link_addr[29:0] register.
REQ-013 A failed SC (mem_sc_mem with link_valid = 0, or link_addr != mem_alu_result[31:2], evaluated in IDLE) SHALL go directly IDLE->DONE with no cache access and sc_result = 0.
REQ-014 A passing SC SHALL perform a write through WAIT; on entry to DONE it SHALL set sc_result = 1 and clear link_valid.
REQ-015 On entry to DONE, an LL SHALL set link_valid = 1 and link_addr = dc_addr[31:2].
REQ-016 On entry to DONE, a plain store whose dc_addr[31:2] equals link_addr SHALL clear link_valid.
REQ-017 Snoop invalidation:
- snoop_inv = 1 with snoop_addr[31:2] == link_addr SHALL clear link_valid on that edge, in any state.
- If this coincides with an LL's DONE entry to the same word, the clear SHALL win (link_valid = 0).
- A snoop arriving while a passing SC is in WAIT SHALL NOT abort it; the SC commits.
REQ-018 Output hold rules:
- sc_result SHALL hold its value until the next SC reaches DONE.
- mem_rdata SHALL hold until the next read reaches DONE.
- Non-SC ops SHALL NOT change sc_result.
REQ-019 dc_ack SHALL be ignored outside WAIT.

Reset
REQ-020 On rst = 1 the block SHALL set: state = IDLE, dc_req = 0, dc_we = 0, dc_addr = 0, dc_wdata = 0, mem_rdata = 0, sc_result = 0, link_valid = 0 and link_addr = 0.
REQ-021 A reset asserted during WAIT SHALL drop dc_req on the next edge and abandon the access; a dc_ack arriving after reset SHALL be ignored.
REQ-022 While rst = 1, mem_stall SHALL follow REQ-011 with state = IDLE.

Verification
REQ-023 Load: mem_mem_read = 1, addr 0x0000_1007, dc_ack 3 cycles after dc_req rises, dc_rdata = 0xDEAD_BEEF -> dc_addr = 0x0000_1004, dc_we = 0, mem_stall high for 4 cycles, mem_rdata = 0xDEAD_BEEF in DONE.
REQ-024 LL/SC pass: LL to 0x200, then SC to 0x200 with data 0x55 -> SC issues dc_we = 1, dc_wdata = 0x55, sc_result = 1, link_valid = 0 afterwards.
REQ-025 SC fail by snoop: LL to 0x200; snoop_inv with snoop_addr 0x203; then SC to 0x200 -> no dc_req, mem_stall high 1 cycle, sc_result = 0.
REQ-026 Simultaneous events: snoop to 0x200 on the same edge as the LL's DONE entry to 0x200 -> link_valid = 0 and a following SC fails; a snoop during a passing SC's WAIT -> sc_result = 1.
REQ-027 Reset mid-WAIT: store in WAIT, rst pulsed 1 cycle, dc_ack arrives 2 cycles later -> dc_req = 0 from the next edge, state = IDLE, all outputs 0, ack ignored.
REQ-028 Read+write conflict: mem_mem_read = 1 and mem_mem_write = 1 -> dc_we = 0 and the access completes as a load.
